// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the extended-Hamming (SEC-DED) code family.
//   par_w(data_w)  : number of Hamming check bits for a data width
//   is_pow2(pos)   : true when a codeword position holds a check bit
//   data_pos(j)    : codeword position of data bit j (shared with the encoder)
//   err_class_e    : decoder verdict for one codeword
// Codeword layout: bit 0 is overall even parity, check bit k sits at
// position 2^k, data bits fill the remaining positions in ascending order.
// -----------------------------------------------------------------------------
package hamming_pkg;

   typedef enum logic [1:0] {
      CLEAN  = 2'd0,
      CORR   = 2'd1,
      UNCORR = 2'd2
   } err_class_e;

   // Smallest p with 2^p >= data_w + p + 1.
   function automatic int par_w(input int data_w);
      int p;
      p = 1;
      while ((1 << p) < (data_w + p + 1)) p = p + 1;
      return p;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Walks positions from 3 upward, skipping check-bit positions, and
   // returns the j-th data slot.
   function automatic int data_pos(input int j);
      int n;
      int found;
      n     = 0;
      found = 0;
      for (int pos = 3; pos < 128; pos++) begin
         if (!is_pow2(pos) && (found == 0)) begin
            if (n == j) found = pos;
            n = n + 1;
         end
      end
      return found;
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
// Combinational syndrome and overall parity of an extended-Hamming codeword.
// Ports:
//   cw       in  CW_W   codeword, bit i = position i, bit 0 = overall parity
//   syndrome out SYN_W  XOR of the positions of all set bits in 1..CW_W-1
//   parity   out 1      XOR of all CW_W bits (0 for a valid codeword)
// -----------------------------------------------------------------------------
module hamming_syndrome #(
   parameter int CW_W  = 13,
   parameter int SYN_W = $clog2(CW_W)
) (
   input  logic [CW_W-1:0]  cw,
   output logic [SYN_W-1:0] syndrome,
   output logic             parity
);

   always_comb begin
      syndrome = '0;
      for (int i = 1; i < CW_W; i++) begin
         for (int k = 0; k < SYN_W; k++) begin
            if (i[k]) syndrome[k] = syndrome[k] ^ cw[i];
         end
      end
      parity = ^cw;
   end

endmodule

// File: rtl/hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_decoder
// Two-stage pipelined SEC-DED decoder. Stage 1 registers the data payload,
// syndrome and overall parity; stage 2 classifies, corrects and presents the
// result. Latency 2 cycles, throughput 1 word per cycle.
// Parameters:
//   DATA_W  data bits per codeword (4..57)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake, in_cw codeword (CW_W bits)
//   out_valid/out_ready output handshake
//   out_data            corrected data (uncorrected when out_uncorrectable)
//   out_syndrome        raw syndrome
//   out_corrected       a single-bit error was corrected
//   out_uncorrectable   double error or syndrome outside the codeword
// Optional build macro HAMMING_ERR_STATS_EN adds:
//   cnt_clear           in  zero both counters (wins over an increment)
//   cnt_corrected       out 16-bit saturating count of corrected outputs
//   cnt_uncorrectable   out 16-bit saturating count of uncorrectable outputs
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both high. Valid never depends on ready; out_* hold steady
// while out_valid=1 and out_ready=0. in_ready is combinational from
// out_ready so a full pipe can shift in the same cycle it drains.
// -----------------------------------------------------------------------------
module hamming_secded_decoder
   import hamming_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW_W   = DATA_W + PAR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [PAR_W-1:0]  out_syndrome,
   output logic              out_corrected,
   output logic              out_uncorrectable
`ifdef HAMMING_ERR_STATS_EN
   ,
   input  logic              cnt_clear,
   output logic [15:0]       cnt_corrected,
   output logic [15:0]       cnt_uncorrectable
`endif
);

   // ---------------------------------------------------------------- control
   logic adv1;
   logic adv2;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [PAR_W-1:0]  s1_syn;
   logic              s1_par;

   logic              s2_valid;
   logic [DATA_W-1:0] s2_data;
   logic [PAR_W-1:0]  s2_syn;
   logic              s2_corr;
   logic              s2_uncorr;

   assign adv2     = !s2_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   // ---------------------------------------------------------------- stage 1
   logic [PAR_W-1:0]  in_syn;
   logic              in_par;
   logic [DATA_W-1:0] in_data;

   hamming_syndrome #(
      .CW_W  (CW_W),
      .SYN_W (PAR_W)
   ) u_syndrome (
      .cw       (in_cw),
      .syndrome (in_syn),
      .parity   (in_par)
   );

   // Check-bit positions never reach the output, so only the data payload is
   // carried forward; a correction aimed at a check bit simply has no effect.
   for (genvar j = 0; j < DATA_W; j++) begin : g_extract
      localparam int POS = data_pos(j);
      assign in_data[j] = in_cw[POS];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_syn  <= in_syn;
            s1_par  <= in_par;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   err_class_e        err_class;
   logic              flip_en;
   logic [DATA_W-1:0] fixed_data;

   always_comb begin
      err_class = CLEAN;
      flip_en   = 1'b0;
      if (s1_par) begin
         if (s1_syn == '0) begin
            err_class = CORR;              // the overall parity bit itself
         end else if (s1_syn <= PAR_W'(CW_W - 1)) begin
            err_class = CORR;
            flip_en   = 1'b1;
         end else begin
            err_class = UNCORR;            // syndrome points past the word
         end
      end else if (s1_syn != '0) begin
         err_class = UNCORR;               // even parity, nonzero syndrome
      end
   end

   for (genvar j = 0; j < DATA_W; j++) begin : g_fix
      localparam int POS = data_pos(j);
      assign fixed_data[j] = s1_data[j] ^ (flip_en && (s1_syn == PAR_W'(POS)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_syn    <= '0;
         s2_corr   <= 1'b0;
         s2_uncorr <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data   <= fixed_data;
            s2_syn    <= s1_syn;
            s2_corr   <= (err_class == CORR);
            s2_uncorr <= (err_class == UNCORR);
         end
      end
   end

   assign out_valid         = s2_valid;
   assign out_data          = s2_data;
   assign out_syndrome      = s2_syn;
   assign out_corrected     = s2_corr;
   assign out_uncorrectable = s2_uncorr;

`ifdef HAMMING_ERR_STATS_EN
   // ---------------------------------------------------------------- stats
   logic out_fire;
   assign out_fire = s2_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         cnt_corrected     <= '0;
         cnt_uncorrectable <= '0;
      end else if (out_fire) begin
         if (s2_corr && (cnt_corrected != 16'hFFFF))
            cnt_corrected <= cnt_corrected + 16'd1;
         if (s2_uncorr && (cnt_uncorrectable != 16'hFFFF))
            cnt_uncorrectable <= cnt_uncorrectable + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_decoder
// Self-checking bench for hamming_secded_decoder with DATA_W=8. Expected
// results come from an index-XOR reference model of the extended Hamming
// code; a negedge monitor pops and compares each output handshake.
// -----------------------------------------------------------------------------
module tb_hamming_secded_decoder;

   localparam int DATA_W = 8;
   localparam int PAR_W  = 4;
   localparam int CW_W   = 13;
   localparam int W      = DATA_W + PAR_W + 2;

   // ------------------------------------------------------ clock and reset
   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic              in_valid;
   logic              in_ready;
   logic [CW_W-1:0]   in_cw;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [PAR_W-1:0]  out_syndrome;
   logic              out_corrected;
   logic              out_uncorrectable;
`ifdef HAMMING_ERR_STATS_EN
   logic              cnt_clear;
   logic [15:0]       cnt_corrected;
   logic [15:0]       cnt_uncorrectable;
`endif

   hamming_secded_decoder #(.DATA_W(DATA_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_cw             (in_cw),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_syndrome      (out_syndrome),
      .out_corrected     (out_corrected),
      .out_uncorrectable (out_uncorrectable)
`ifdef HAMMING_ERR_STATS_EN
      ,
      .cnt_clear         (cnt_clear),
      .cnt_corrected     (cnt_corrected),
      .cnt_uncorrectable (cnt_uncorrectable)
`endif
   );

   // ------------------------------------------------------ scoreboard state
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int passes = 0;
   logic rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------ reference model
   function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] cw;
      int j;
      int s;
      cw = '0;
      j  = 0;
      s  = 0;
      for (int pos = 1; pos < CW_W; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[j];
            j++;
         end
      end
      for (int pos = 1; pos < CW_W; pos++) if (cw[pos]) s = s ^ pos;
      for (int k = 0; k < PAR_W; k++) cw[1 << k] = s[k];
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [W-1:0] decode_ref(input logic [CW_W-1:0] cw);
      logic [CW_W-1:0]   f;
      logic [DATA_W-1:0] d;
      logic              p;
      logic              corr;
      logic              unc;
      int s;
      int j;
      s    = 0;
      f    = cw;
      d    = '0;
      corr = 1'b0;
      unc  = 1'b0;
      for (int pos = 1; pos < CW_W; pos++) if (cw[pos]) s = s ^ pos;
      p = ^cw;
      if (p) begin
         if (s == 0) corr = 1'b1;
         else if (s < CW_W) begin
            f[s] = ~f[s];
            corr = 1'b1;
         end else unc = 1'b1;
      end else if (s != 0) unc = 1'b1;
      j = 0;
      for (int pos = 1; pos < CW_W; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            d[j] = f[pos];
            j++;
         end
      end
      return {d, s[PAR_W-1:0], corr, unc};
   endfunction

   // ------------------------------------------------------ driver tasks
   task automatic send(input logic [CW_W-1:0] cw, input logic [W-1:0] exp);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_cw    = cw;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'(1));
      else exp_q.push_back(exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         in_cw = CW_W'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n == 200) check("drain_timeout", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW_W-1:0] random_cw();
      logic [CW_W-1:0] cw;
      int a;
      int b;
      cw = encode(DATA_W'($urandom));
      a  = $urandom_range(0, CW_W - 1);
      b  = (a + $urandom_range(1, CW_W - 1)) % CW_W;
      case ($urandom_range(0, 4))
         0: ;
         1: cw[a] = ~cw[a];
         2: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
         3: begin
            cw[a] = ~cw[a];
            cw[b] = ~cw[b];
            a = $urandom_range(0, CW_W - 1);
            cw[a] = ~cw[a];
         end
         default: cw = CW_W'($urandom);
      endcase
      return cw;
   endfunction

   // ------------------------------------------------------ output ready
   always begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
   end

   // ------------------------------------------------------ monitor
   int           occ = 0;
   logic         holding = 1'b0;
   logic [W-1:0] held;

   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      act = {out_data, out_syndrome, out_corrected, out_uncorrectable};
      if (rst) begin
         occ     = 0;
         holding = 1'b0;
      end else begin
         check("in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
         if (holding) begin
            check("stall_hold", 64'({out_valid, act}), 64'({1'b1, held}));
            holding = 1'b0;
         end
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) check("unexpected_output", 64'(out_valid), 64'(0));
               else begin
                  e = exp_q.pop_front();
                  check("word", 64'(act), 64'(e));
               end
            end else begin
               holding = 1'b1;
               held    = act;
            end
         end
         if (in_valid && in_ready) occ++;
         if (out_valid && out_ready) occ--;
      end
   end

   // ------------------------------------------------------ test sequence
   initial begin
      logic [CW_W-1:0] cw;
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_cw     = '0;
      out_ready = 1'b0;
`ifdef HAMMING_ERR_STATS_EN
      cnt_clear = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_flags", 64'({out_syndrome, out_corrected, out_uncorrectable}), 64'(0));
      @(posedge clk);
      #1;

      // Clean word and two-cycle latency.
      out_ready = 1'b1;
      send(13'h144E, {8'hA5, 4'd0, 1'b0, 1'b0});
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_c1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("latency_c2", 64'(out_valid), 64'(1));
      check("t1_data", 64'(out_data), 64'(8'hA5));
      @(posedge clk);
      #1;

      send(13'h140E, {8'hA5, 4'd6, 1'b1, 1'b0});   // data bit 2 flipped
      send(13'h144F, {8'hA5, 4'd0, 1'b1, 1'b0});   // overall parity flipped
      send(13'h1406, {8'hA0, 4'd5, 1'b0, 1'b1});   // double error
      idle(1);
      drain();

      // Randomized stream with random gaps and random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         cw = random_cw();
         send(cw, decode_ref(cw));
      end
      idle(1);
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Reset with two words in flight.
      out_ready = 1'b0;
      cw = encode(8'h3C);
      send(cw, decode_ref(cw));
      cw = encode(8'hC3);
      send(cw, decode_ref(cw));
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      check("midrst_out_data", 64'(out_data), 64'(0));
      check("midrst_flags", 64'({out_syndrome, out_corrected, out_uncorrectable}), 64'(0));
      out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_stale", 64'(seen), 64'(0));
      @(posedge clk);
      #1;

`ifdef HAMMING_ERR_STATS_EN
      check("cnt_after_rst", 64'({cnt_corrected, cnt_uncorrectable}), 64'(0));
      cw = 13'h144E ^ 13'h0020; send(cw, decode_ref(cw));
      cw = 13'h144E ^ 13'h0001; send(cw, decode_ref(cw));
      cw = 13'h144E ^ 13'h0200; send(cw, decode_ref(cw));
      cw = 13'h1406;            send(cw, decode_ref(cw));
      idle(1);
      drain();
      check("cnt_corrected", 64'(cnt_corrected), 64'(3));
      check("cnt_uncorrectable", 64'(cnt_uncorrectable), 64'(1));
      cnt_clear = 1'b1;
      @(posedge clk);
      #1;
      cnt_clear = 1'b0;
      @(negedge clk);
      check("cnt_cleared", 64'({cnt_corrected, cnt_uncorrectable}), 64'(0));
      @(posedge clk);
      #1;
`endif

      check("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
